// File: rtl/inst_queue_u.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular FIFO of
// {pc, instr} pairs with flush, registered occupancy and no in->out bypass.
module inst_queue_u #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH)+1-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   mem_q [DEPTH];
  logic          push, pop;

  // Ready and valid derive only from registered occupancy, so a full queue
  // never accepts a push even when decode is popping in the same cycle.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // Gating with reset keeps the storage untouched on an edge seen while reset is low.
  assign push = in_valid & in_ready & ~flush & reset;
  assign pop  = out_valid & out_ready & ~flush & reset;

  assign out_pc    = out_valid ? mem_q[rd_ptr_q][63:32] : 32'h0;
  assign out_instr = out_valid ? mem_q[rd_ptr_q][31:0]  : 32'h0;

  // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_pc, in_instr};
  end

endmodule

// File: tb/tb_inst_queue_u.sv
// Directed bench for inst_queue_u (DEPTH=4): fill, drain, streaming with wrap,
// full-with-pop, flush and asynchronous reset.
module tb_inst_queue_u;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;

  int vectors = 0;
  int errors  = 0;

  inst_queue_u #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    out_ready = 1'b0; flush = 1'b0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    #10 reset = 1'b1;

    // Fill with pc 0,4,8,12 while decode stalls
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(4 * i); in_instr = 32'hA000_0000 + 32'(i);
      tick();
      chk($sformatf("fill_count_%0d", i), 32'(count), 32'(i + 1));
      chk($sformatf("fill_head_%0d", i), out_pc, 0);
      chk($sformatf("fill_valid_%0d", i), 32'(out_valid), 1);
    end
    chk("full_in_ready", 32'(in_ready), 0);
    in_pc = 32'd16; in_instr = 32'hDEAD_BEEF;
    tick();
    chk("full_5th_count", 32'(count), 4);
    chk("full_5th_head", out_pc, 0);

    // Drain in order
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_pc_%0d", i), out_pc, 32'(4 * i));
      chk($sformatf("drain_instr_%0d", i), out_instr, 32'hA000_0000 + 32'(i));
      tick();
    end
    chk("drain_out_valid", 32'(out_valid), 0);
    chk("drain_count", 32'(count), 0);
    chk("drain_out_instr", out_instr, 0);
    chk("drain_out_pc", out_pc, 0);
    tick();
    chk("empty_pop_count", 32'(count), 0);

    // Streaming: out_pc tracks the pc pushed one cycle earlier, across many wraps
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_pc = 32'h200 + 32'(4 * i); in_instr = 32'hB000_0000 + 32'(i);
      tick();
      chk($sformatf("stream_count_%0d", i), 32'(count), 1);
      chk($sformatf("stream_pc_%0d", i), out_pc, 32'h200 + 32'(4 * i));
      chk($sformatf("stream_instr_%0d", i), out_instr, 32'hB000_0000 + 32'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_count", 32'(count), 0);

    // Full with pop: only the pop happens
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_pc = 32'h300 + 32'(4 * i); in_instr = 32'hC000_0000 + 32'(i);
      tick();
    end
    chk("fp_full_count", 32'(count), 4);
    in_pc = 32'h400; out_ready = 1'b1;
    tick();
    chk("fp_count", 32'(count), 3);
    chk("fp_in_ready", 32'(in_ready), 1);
    chk("fp_head", out_pc, 32'h304);

    // Flush with in_valid and out_ready high, then again on the next cycle
    flush = 1'b1; in_pc = 32'h500;
    tick();
    chk("flush_count", 32'(count), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_out_pc", out_pc, 0);
    tick();
    chk("flush2_count", 32'(count), 0);
    flush = 1'b0; out_ready = 1'b0; in_pc = 32'h100; in_instr = 32'h1111_1111;
    tick();
    chk("post_flush_pc", out_pc, 32'h100);
    chk("post_flush_instr", out_instr, 32'h1111_1111);
    chk("post_flush_count", 32'(count), 1);
    in_pc = 32'h104; in_instr = 32'h2222_2222;
    tick();
    chk("pre_rst_count", 32'(count), 2);
    chk("pre_rst_head", out_pc, 32'h100);

    // Asynchronous reset between edges, held across one edge with in_valid high
    in_pc = 32'h108;
    #2 reset = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_out_pc", out_pc, 0);
    tick();
    chk("arst_edge_count", 32'(count), 0);
    #2 reset = 1'b1;
    in_pc = 32'h600; in_instr = 32'h6666_6666;
    tick();
    chk("after_rst_pc", out_pc, 32'h600);
    chk("after_rst_instr", out_instr, 32'h6666_6666);
    chk("after_rst_count", 32'(count), 1);
    in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/inst_queue_u.md
INST_QUEUE_U -- requirements
Module: inst_queue_u

Interface
REQ-001 Parameter: DEPTH, default 4, number of queue entries; SHALL be a power of two, 2 to 16.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-004 Port: in_valid  input  1  fetch stage presents a valid pc/instr pair.
REQ-005 Port: in_pc  input  32  PC of the presented instruction.
REQ-006 Port: in_instr  input  32  instruction word from instruction ROM.
REQ-007 Port: in_ready  output  1  queue accepts a push this cycle.
REQ-008 Port: out_valid  output  1  head entry valid toward decode.
REQ-009 Port: out_pc  output  32  PC of head entry.
REQ-010 Port: out_instr  output  32  instruction of head entry.
REQ-011 Port: out_ready  input  1  decode consumes head entry this cycle.
REQ-012 Port: flush  input  1  taken branch/jump redirect; discard all entries.
REQ-013 Port: count  output  $clog2(DEPTH)+1  current number of valid entries.

Function
REQ-014 Circular buffer: DEPTH entries of {pc[31:0], instr[31:0]}, write pointer, read pointer, occupancy counter; pointers wrap DEPTH-1 -> 0.
REQ-015 push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
REQ-016 in_ready = (count < DEPTH), combinational from registered count only; no dependence on out_ready (no pass-through when full).
REQ-017 out_valid = (count != 0); out_pc/out_instr = head entry when out_valid, else 32'h0.
REQ-018 Push: write entry at write pointer, advance write pointer by 1 at rising edge.
REQ-019 Pop: advance read pointer by 1 at rising edge.
REQ-020 count update: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
REQ-021 Latency: a pushed entry appears on out_* with out_valid=1 on the cycle after the push edge; no combinational bypass from in_* to out_*, even when empty.
REQ-022 Ordering strictly FIFO; entries never duplicated, dropped or reordered except by flush.
REQ-023 Full (count=DEPTH): in_ready=0; pop in that cycle makes in_ready=1 the following cycle.
REQ-024 Empty (count=0): out_valid=0; out_ready ignored; count never underflows.
REQ-025 Simultaneous push and pop at count=1: head replaced by new entry next cycle, count stays 1.
REQ-026 flush=1 at a rising edge: read pointer, write pointer, count set to 0; any in_valid/out_ready that cycle ignored (no push, no pop); out_valid=0 the next cycle.
REQ-027 flush has priority over push and pop; flush on consecutive cycles keeps queue empty.
REQ-028 Storage contents need not be cleared by flush or reset; only pointers/count define validity.

Reset
REQ-029 reset low: write pointer, read pointer, count = 0 asynchronously; out_valid=0, out_pc=0, out_instr=0, in_ready=1, count output=0 while reset low.
REQ-030 Reset asserted mid-operation discards all entries; first push after reset release is the first entry output.
REQ-031 No push or pop on the rising edge where reset is low.

Verification
REQ-032 Fill: DEPTH=4, out_ready=0, push pc 0,4,8,12 on consecutive cycles -> count 1,2,3,4; in_ready=0 after 4th push; 5th in_valid not accepted.
REQ-033 Drain: from full, out_ready=1 for 4 cycles -> out_pc 0,4,8,12 in order, then out_valid=0, count=0, out_instr=0.
REQ-034 Streaming: in_valid=1 and out_ready=1 continuously, pc incrementing by 4 -> count steady at 1 after first cycle, out_pc lags in_pc by exactly 1 cycle, pointer wrap across entry 3->0 lossless over 20 pushes.
REQ-035 Full with pop: count=4, out_ready=1, in_valid=1 -> pop only, count=3, in_ready=1 next cycle.
REQ-036 Flush: count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0; following push of pc 0x100 is output first.
REQ-037 Async reset: count=2, drive reset low between clock edges -> count=0 and out_valid=0 before next edge; after release, queue behaves as after power-up.
